// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and the load-use hazard detect helper.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A load result reaches ID too late for forwarding only when a live source matches a non-zero rd.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != REG_X0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for pipeline perf events.
module pipe_ctrl_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Holds at all-ones instead of wrapping so a long run never reads as a small value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline (load-use, redirect, MDU).
// Performance counters are built only when PIP E_CTRL_PERF_EN is defined: PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_MAX_CYCLES = 34,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memRead,
    input  logic             id_ex_mdu_op,
    input  logic             ex_redirect,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] cnt_load_stall,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_mdu_cycles
);

    localparam int WAIT_W = $clog2(MDU_MAX_CYCLES + 1);

    ctrl_state_e       state;
    ctrl_state_e       state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_set;
    logic              load_use;
    logic              ev_load_stall;
    logic              ev_flush;
    logic              ev_mdu_cycle;

    logic raw_pc_write;
    logic raw_if_id_write;
    logic raw_id_ex_write;
    logic raw_if_id_flush;
    logic raw_id_ex_flush;
    logic raw_bubble;
    logic raw_mdu_start;

    assign load_use = load_use_hit(id_ex_memRead, id_ex_rd, id_rs1, id_rs2,
                                   id_uses_rs1, id_uses_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Counts wait cycles of the current MDU op; the start cycle is spent in RUN and excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == RUN) begin
            wait_cnt <= '0;
        end else if (!mdu_done) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_timeout <= 1'b0;
        end else if (timeout_set) begin
            mdu_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        raw_pc_write    = 1'b1;
        raw_if_id_write = 1'b1;
        raw_id_ex_write = 1'b1;
        raw_if_id_flush = 1'b0;
        raw_id_ex_flush = 1'b0;
        raw_bubble      = 1'b0;
        raw_mdu_start   = 1'b0;
        timeout_set     = 1'b0;
        ev_load_stall   = 1'b0;
        ev_flush        = 1'b0;
        ev_mdu_cycle    = 1'b0;

        case (state)
            RUN: begin
                if (ex_redirect) begin
                    raw_if_id_flush = 1'b1;
                    raw_id_ex_flush = 1'b1;
                    ev_flush        = 1'b1;
                end else if (id_ex_mdu_op) begin
                    raw_mdu_start   = 1'b1;
                    raw_pc_write    = 1'b0;
                    raw_if_id_write = 1'b0;
                    raw_id_ex_write = 1'b0;
                    raw_bubble      = 1'b1;
                    state_next      = MDU_WAIT;
                end else if (load_use) begin
                    raw_pc_write    = 1'b0;
                    raw_if_id_write = 1'b0;
                    raw_id_ex_flush = 1'b1;
                    ev_load_stall   = 1'b1;
                end
            end
            MDU_WAIT: begin
                ev_mdu_cycle = 1'b1;
                if (mdu_done) begin
                    state_next = RUN;
                end else begin
                    raw_pc_write    = 1'b0;
                    raw_if_id_write = 1'b0;
                    raw_id_ex_write = 1'b0;
                    raw_bubble      = 1'b1;
                    if (wait_cnt == WAIT_W'(MDU_MAX_CYCLES - 1)) begin
                        timeout_set = 1'b1;
                        state_next  = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Controls are forced inactive for as long as rst_n is held low, not just at the next edge.
    always_comb begin
        pc_write      = rst_n & raw_pc_write;
        if_id_write   = rst_n & raw_if_id_write;
        id_ex_write   = rst_n & raw_id_ex_write;
        if_id_flush   = rst_n & raw_if_id_flush;
        id_ex_flush   = rst_n & raw_id_ex_flush;
        ex_mem_bubble = rst_n & raw_bubble;
        mdu_start     = rst_n & raw_mdu_start;
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_load_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_load_stall),
        .clr   (1'b0),
        .count (cnt_load_stall)
    );

    pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_flush),
        .clr   (1'b0),
        .count (cnt_flush)
    );

    pipe_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cnt_mdu_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_mdu_cycle),
        .clr   (1'b0),
        .count (cnt_mdu_cycles)
    );
`else
    logic perf_events_unused;
    assign perf_events_unused = ev_load_stall ^ ev_flush ^ ev_mdu_cycle;
    assign cnt_load_stall     = '0;
    assign cnt_flush          = '0;
    assign cnt_mdu_cycles     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; counter expectations
// follow whether PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_ex_rd;
    logic        id_ex_memRead;
    logic        id_ex_mdu_op;
    logic        ex_redirect;
    logic        mdu_done;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        mdu_start;
    logic        mdu_timeout;
    logic [31:0] cnt_load_stall;
    logic [31:0] cnt_flush;
    logic [31:0] cnt_mdu_cycles;

    int compared;
    int mismatched;

    pipeline_hazard_ctrl #(
        .MDU_MAX_CYCLES (34),
        .CNT_W          (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_memRead  (id_ex_memRead),
        .id_ex_mdu_op   (id_ex_mdu_op),
        .ex_redirect    (ex_redirect),
        .mdu_done       (mdu_done),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .mdu_start      (mdu_start),
        .mdu_timeout    (mdu_timeout),
        .cnt_load_stall (cnt_load_stall),
        .cnt_flush      (cnt_flush),
        .cnt_mdu_cycles (cnt_mdu_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mem_read, input logic mdu_op,
                                 input logic redirect, input logic done);
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_uses_rs1   = u1;
        id_uses_rs2   = u2;
        id_ex_rd      = rd;
        id_ex_memRead = mem_read;
        id_ex_mdu_op  = mdu_op;
        ex_redirect   = redirect;
        mdu_done      = done;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst pc_write", pc_write, 0);
        checkOutput("rst if_id_write", if_id_write, 0);
        checkOutput("rst id_ex_write", id_ex_write, 0);
        checkOutput("rst bubble", ex_mem_bubble, 0);
        checkOutput("rst timeout", mdu_timeout, 0);
        checkOutput("rst cnt_mdu", cnt_mdu_cycles, 0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("run pc_write", pc_write, 1);
        checkOutput("run id_ex_write", id_ex_write, 1);
        checkOutput("run id_ex_flush", id_ex_flush, 0);

        // Load x5 in EX, ID reads x5 via rs1: one stall cycle
        nextCycle();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu pc_write", pc_write, 0);
        checkOutput("lu if_id_write", if_id_write, 0);
        checkOutput("lu id_ex_write", id_ex_write, 1);
        checkOutput("lu id_ex_flush", id_ex_flush, 1);
        checkOutput("lu if_id_flush", if_id_flush, 0);
        nextCycle();
        idle();
        #1;
        checkOutput("lu next pc_write", pc_write, 1);
        checkOutput("lu next id_ex_flush", id_ex_flush, 0);
        checkOutput("lu cnt_load_stall", cnt_load_stall, PERF ? 1 : 0);

        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("x0 pc_write", pc_write, 1);
        checkOutput("x0 id_ex_flush", id_ex_flush, 0);

        nextCycle();
        applyStimulus(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rs2 unused pc_write", pc_write, 1);
        checkOutput("rs2 unused id_ex_flush", id_ex_flush, 0);

        // Redirect outranks a simultaneous load-use
        nextCycle();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("redir if_id_flush", if_id_flush, 1);
        checkOutput("redir id_ex_flush", id_ex_flush, 1);
        checkOutput("redir pc_write", pc_write, 1);
        checkOutput("redir if_id_write", if_id_write, 1);
        nextCycle();
        idle();
        #1;
        checkOutput("redir cnt_flush", cnt_flush, PERF ? 1 : 0);
        checkOutput("redir cnt_load_stall", cnt_load_stall, PERF ? 1 : 0);

        // MDU op with done in the fifth cycle after start
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("mdu start", mdu_start, 1);
        checkOutput("mdu start pc_write", pc_write, 0);
        checkOutput("mdu start id_ex_write", id_ex_write, 0);
        checkOutput("mdu start bubble", ex_mem_bubble, 1);
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            #1;
            checkOutput("mdu wait start", mdu_start, 0);
            checkOutput("mdu wait pc_write", pc_write, 0);
            checkOutput("mdu wait bubble", ex_mem_bubble, 1);
        end
        nextCycle();
        mdu_done = 1'b1;
        #1;
        checkOutput("mdu done bubble", ex_mem_bubble, 0);
        checkOutput("mdu done pc_write", pc_write, 1);
        checkOutput("mdu done id_ex_write", id_ex_write, 1);
        checkOutput("mdu done start", mdu_start, 0);
        nextCycle();
        idle();
        #1;
        checkOutput("mdu after pc_write", pc_write, 1);
        checkOutput("mdu after bubble", ex_mem_bubble, 0);
        checkOutput("mdu cnt cycles", cnt_mdu_cycles, PERF ? 5 : 0);

        // Done in the start cycle is ignored; done on the first wait cycle is minimum latency
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("min start", mdu_start, 1);
        checkOutput("min start bubble", ex_mem_bubble, 1);
        nextCycle();
        #1;
        checkOutput("min done bubble", ex_mem_bubble, 0);
        checkOutput("min done start", mdu_start, 0);
        nextCycle();
        idle();
        #1;
        checkOutput("min cnt cycles", cnt_mdu_cycles, PERF ? 6 : 0);

        // MDU never finishes: watchdog after 34 wait cycles
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 34; i++) begin
            nextCycle();
            idle();
            #1;
            checkOutput("wd wait bubble", ex_mem_bubble, 1);
            checkOutput("wd wait timeout", mdu_timeout, 0);
        end
        nextCycle();
        #1;
        checkOutput("wd timeout", mdu_timeout, 1);
        checkOutput("wd run bubble", ex_mem_bubble, 0);
        checkOutput("wd run pc_write", pc_write, 1);
        checkOutput("wd cnt cycles", cnt_mdu_cycles, PERF ? 40 : 0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("wd sticky", mdu_timeout, 1);

        // Reset in the middle of an MDU wait
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        idle();
        nextCycle();
        #1;
        checkOutput("mid wait bubble", ex_mem_bubble, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid rst pc_write", pc_write, 0);
        checkOutput("mid rst id_ex_write", id_ex_write, 0);
        checkOutput("mid rst bubble", ex_mem_bubble, 0);
        checkOutput("mid rst timeout", mdu_timeout, 0);
        checkOutput("mid rst cnt_mdu", cnt_mdu_cycles, 0);
        checkOutput("mid rst cnt_flush", cnt_flush, 0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("rel pc_write", pc_write, 1);
        checkOutput("rel bubble", ex_mem_bubble, 0);
        checkOutput("rel timeout", mdu_timeout, 0);
        nextCycle();
        #1;
        checkOutput("rel run bubble", ex_mem_bubble, 0);
        checkOutput("rel run pc_write", pc_write, 1);
        checkOutput("rel cnt_load_stall", cnt_load_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
